reciprocal_scheduler: RTL

//  Shares one fully pipelined FP32 reciprocal unit (fixed latency, no stall input) among N_REQ

---
 rtl/reciprocal_scheduler.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/reciprocal_scheduler.sv
// Round-robin front end sharing one fixed-latency FP32 reciprocal pipe among
// N_REQ requesters. A tag pipe tracks requester ids alongside the external
// unit. Results land in an output FIFO whose depth is the credit pool.
module reciprocal_scheduler #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned LAT        = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned IDW        = 2
) (
    input  logic                   clk,
    input  logic                   areset_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [32*N_REQ-1:0]    req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [31:0]            rcp_a,
    input  logic [31:0]            rcp_q,
    output logic                   out_valid,
    output logic [31:0]            out_data,
    output logic [IDW-1:0]         out_id,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned SW = IDW + 1;

    typedef struct packed {
        logic [31:0]    data;
        logic [IDW-1:0] id;
    } result_t;

    logic [CW-1:0]  credits;
    logic [CW-1:0]  credits_nxt;
    logic [CW-1:0]  fifo_cnt;
    logic [CW-1:0]  fifo_cnt_nxt;
    logic [IDW-1:0] ptr;
    logic           arb_en;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   gnt_id;
    logic             xfer;
    logic [SW-1:0]    arb_sum;
    logic [IDW-1:0]   arb_idx;

    logic [31:0]      lane_data [N_REQ];

    logic             issue_vld;
    logic [IDW-1:0]   issue_id;
    logic [LAT-1:0]   tag_vld;
    logic [IDW-1:0]   tag_id [LAT];

    result_t          mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             fifo_wr;
    logic             fifo_pop;

    int unsigned      inflight;

    // Unpack the flat operand bus into per-lane words
    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign lane_data[g] = req_data[32*g +: 32];
    end

    // Round-robin search starting at ptr; no grant without a free credit
    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        xfer    = 1'b0;
        arb_sum = '0;
        arb_idx = '0;
        if (arb_en && (credits != '0)) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                arb_sum = {1'b0, ptr} + SW'(k);
                if (arb_sum >= SW'(N_REQ)) begin
                    arb_sum = arb_sum - SW'(N_REQ);
                end
                arb_idx = IDW'(arb_sum);
                if (!xfer && req_valid[arb_idx]) begin
                    xfer            = 1'b1;
                    grant[arb_idx]  = 1'b1;
                    gnt_id          = arb_idx;
                end
            end
        end
    end

    assign req_ready = grant;
    assign fifo_wr   = tag_vld[LAT-1];
    assign fifo_pop  = out_valid && out_ready;
    assign out_data  = mem[rd_ptr].data;
    assign out_id    = mem[rd_ptr].id;

    // Next credit and occupancy counts; simultaneous inc/dec cancel
    always_comb begin
        credits_nxt = credits;
        case ({xfer, fifo_pop})
            2'b10:   credits_nxt = credits - CW'(1);
            2'b01:   credits_nxt = credits + CW'(1);
            default: credits_nxt = credits;
        endcase
        fifo_cnt_nxt = fifo_cnt;
        case ({fifo_wr, fifo_pop})
            2'b10:   fifo_cnt_nxt = fifo_cnt + CW'(1);
            2'b01:   fifo_cnt_nxt = fifo_cnt - CW'(1);
            default: fifo_cnt_nxt = fifo_cnt;
        endcase
    end

    // Arbiter state, credits and status flags
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            arb_en    <= 1'b0;
            ptr       <= '0;
            credits   <= CW'(FIFO_DEPTH);
            fifo_cnt  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            arb_en    <= 1'b1;
            if (xfer) begin
                ptr <= (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);
            end
            credits   <= credits_nxt;
            fifo_cnt  <= fifo_cnt_nxt;
            busy      <= (credits_nxt != CW'(FIFO_DEPTH));
            out_valid <= (fifo_cnt_nxt != '0);
        end
    end

    // Issue register plus LAT tag stages: the operand is on rcp_a one cycle
    // after transfer and its result returns LAT cycles later, so the id
    // needs LAT+1 register stages to meet rcp_q at the tail
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rcp_a     <= '0;
            issue_vld <= 1'b0;
            issue_id  <= '0;
            tag_vld   <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            rcp_a     <= xfer ? lane_data[gnt_id] : 32'h0;
            issue_vld <= xfer;
            issue_id  <= xfer ? gnt_id : '0;
            tag_vld[0] <= issue_vld;
            tag_id[0]  <= issue_id;
            for (int unsigned k = 1; k < LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    // Output FIFO; credits guarantee a free slot for every tagged result
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (fifo_wr) begin
                mem[wr_ptr] <= '{data: rcp_q, id: tag_id[LAT-1]};
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

    // Count of operations between transfer and FIFO write
    always_comb begin
        inflight = 32'(issue_vld);
        for (int unsigned k = 0; k < LAT; k++) begin
            inflight = inflight + 32'(tag_vld[k]);
        end
    end

    a_credit_conservation: assert property (@(posedge clk) disable iff (!areset_n)
        (32'(credits) + 32'(fifo_cnt) + inflight) == FIFO_DEPTH);
    a_credit_underflow: assert property (@(posedge clk) disable iff (!areset_n)
        !(xfer && (credits == '0)));
    a_credit_overflow: assert property (@(posedge clk) disable iff (!areset_n)
        !(fifo_pop && !xfer && (credits == CW'(FIFO_DEPTH))));

endmodule
